sdram_cmd_arbiter: RTL and testbench
====================================

Name: sdram_cmd_arbiter

Overview:
Shares the async SDRAM controller's single command queue (writer FIFO) and single-word read-return queue among three requesters: video stream prefetch, host framebuffer port and rasterizer port. It grants one command per cycle and encodes it into the 41-bit writer word. It routes single-word read data back to the issuing port in order, and bounds outstanding stream bursts. It sits between the framebuffer front-ends and async_sdram_ctrl, in the clk_pix domain.

Parameters:
MAX_BURSTS, 2, maximum stream burst reads issued but not yet consumed (1..7).
TAG_DEPTH, 4, depth of the in-order read-tag FIFO (power of two, >=2).

Ports:
clk_pix  in  1  pixel/system clock; all logic on its rising edge
reset_i  in  1  synchronous, active-high reset
h_sel_i  in  1  host request; held until h_ack_o
h_wr_i  in  1  host write (1) / read (0)
h_addr_i  in  24  host word address
h_data_i  in  16  host write data
h_ack_o  out  1  host completion pulse
h_data_o  out  16  host read data, valid with h_ack_o
r_sel_i, r_wr_i, r_addr_i, r_data_i, r_ack_o, r_data_o  (same widths and semantics as h_*, rasterizer port)
s_req_i  in  1  stream burst request (level)
s_addr_i  in  24  burst base address (8-word aligned)
s_ack_o  out  1  pulse: burst command enqueued
s_burst_done_i  in  1  pulse: stream consumer dequeued one burst
writer_d_o  out  41  {wr, addr[23:0], data[15:0]}
writer_enq_o  out  1  enqueue pulse
writer_full_i  in  1  command FIFO full
reader_q_i  in  16  read-return data (valid cycle after reader_deq_o)
reader_empty_i  in  1  read-return FIFO empty
reader_deq_o  out  1  read-return dequeue pulse

Behaviour:
- Reset: all *_ack_o, writer_enq_o, reader_deq_o = 0; h_data_o, r_data_o, writer_d_o = 0; inflight = 0; tag FIFO emptied; rr pointer = host. Reset mid-read discards tags; stale returns are not drained.
- Eligibility. Stream: s_req_i && inflight < MAX_BURSTS && !s_ack_o. Host/raster: sel && !busy_x && !ack_x. busy_x is set when port x's read is enqueued and cleared on its ack. A read additionally needs the tag FIFO not full.
- Grant, evaluated every cycle when !writer_full_i:
  - The stream has fixed priority.
  - Otherwise host and raster alternate round-robin; the rr pointer flips after a host/raster grant.
  - Registered outputs: writer_enq_o = 1 for one cycle at N+1.
- Encoding:
  - Write: {1, addr, data}.
  - Single read: {0, addr, 16'h0}.
  - Burst read: {0, s_addr_i, 16'h1}.
- Writes: ack_x pulses in the same cycle as writer_enq_o; the write is fire-and-forget.
- Reads:
  - Push tag (0 = host, 1 = raster) at enqueue.
  - When tag FIFO not empty, !reader_empty_i and no deq in flight: reader_deq_o pulses at cycle M.
  - reader_q_i is sampled at M+1; the tag is popped.
  - Target data_o and ack_o are registered at M+2.
  - Read latency is at least 4 cycles after grant.
- Stream: s_ack_o pulses with writer_enq_o. Inflight +1 on burst enqueue, -1 on s_burst_done_i; both together leave it unchanged. s_burst_done_i at 0 is ignored (saturate).
- writer_full_i high: no grant; pending requests wait with no loss.
- Return FSM states: R_IDLE -> R_DEQ (deq pulse) -> R_CAP (capture, pop) -> R_IDLE.
- Simultaneous host/raster ack: both are allowed in the same cycle (one write, one read return).

Optional Feature:
ARB_STATS_EN.
- Defined: adds outputs stat_grants_h_o, stat_grants_r_o, stat_grants_s_o (32 bits each, +1 per grant) and stat_stall_o (32 bits, +1 per cycle with an eligible requester while writer_full_i). All counters wrap and are zeroed on reset_i.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sdram_arb_pkg holds:
  - requester enum (REQ_HOST, REQ_RASTER, REQ_STREAM);
  - return-FSM state enum;
  - cmd_t packed struct {wr, addr, data};
  - constants CMD_WIDTH = 41, BURST_WORDS = 8, BURST_FLAG = 16'h1.
- One sub-module, arb_tag_fifo: synchronous 1-bit FIFO with push, pop, full, empty and TAG_DEPTH depth.

Test Plan:
- Host write addr 24'h000010, data 16'hABCD, writer_full_i = 0 -> writer_d_o = {1, 24'h000010, 16'hABCD}, enq at N+1, h_ack_o at N+1.
- Host read 24'h000020 while raster reads 24'h000030; returns 16'h1111 then 16'h2222 -> host gets 16'h1111, raster gets 16'h2222, grant order host then raster.
- s_req_i held high with MAX_BURSTS = 2, no done -> exactly 2 burst enqueues (low 16 bits = 16'h0001). One s_burst_done_i pulse -> third burst is issued.
- Stream, host and raster requesting together -> grant order: stream, then host/raster alternating. Raster is never starved over 10 host requests.
- writer_full_i high for 5 cycles with a host write pending -> no enq; a single enq and ack the cycle after full drops.
- reset_i asserted while a read is in R_DEQ -> acks stay 0, tag FIFO empty, inflight = 0 the next cycle.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM command arbiter: requester ids,
// read-return FSM states and the 41-bit writer command word layout.
package sdram_arb_pkg;

    localparam int              CMD_WIDTH   = 41;
    localparam int              BURST_WORDS = 8;
    localparam logic [15:0]     BURST_FLAG  = 16'h0001;
    localparam logic [23:0]     BURST_MASK  = ~(24'(BURST_WORDS) - 24'd1);

    typedef enum logic [1:0] {
        REQ_HOST   = 2'd0,
        REQ_RASTER = 2'd1,
        REQ_STREAM = 2'd2
    } req_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DEQ  = 2'd1,
        R_CAP  = 2'd2
    } ret_state_e;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] data;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic wr, input logic [23:0] addr,
                                      input logic [15:0] data);
        cmd_t c;
        c.wr   = wr;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit read-tag FIFO (0 = host, 1 = raster); pushes when full and
// pops when empty are ignored.
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_data,
    output logic o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [DEPTH-1:0] r_mem;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    // Pointer and storage update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Arbitrates stream/host/raster onto the SDRAM writer queue and routes read returns.
// Define ARB_STATS_EN to add grant and stall counters.
module sdram_cmd_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_BURSTS = 2,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                 clk_pix,
    input  logic                 reset_i,
    input  logic                 h_sel_i,
    input  logic                 h_wr_i,
    input  logic [23:0]          h_addr_i,
    input  logic [15:0]          h_data_i,
    output logic                 h_ack_o,
    output logic [15:0]          h_data_o,
    input  logic                 r_sel_i,
    input  logic                 r_wr_i,
    input  logic [23:0]          r_addr_i,
    input  logic [15:0]          r_data_i,
    output logic                 r_ack_o,
    output logic [15:0]          r_data_o,
    input  logic                 s_req_i,
    input  logic [23:0]          s_addr_i,
    output logic                 s_ack_o,
    input  logic                 s_burst_done_i,
    output logic [CMD_WIDTH-1:0] writer_d_o,
    output logic                 writer_enq_o,
    input  logic                 writer_full_i,
    input  logic [15:0]          reader_q_i,
    input  logic                 reader_empty_i,
    output logic                 reader_deq_o
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          stat_grants_h_o,
    output logic [31:0]          stat_grants_r_o,
    output logic [31:0]          stat_grants_s_o,
    output logic [31:0]          stat_stall_o
`endif
);

    localparam logic [2:0] MAX_B = 3'(MAX_BURSTS);

    logic [2:0]  r_inflight;
    logic        r_busy_h;
    logic        r_busy_r;
    req_e        r_rr;
    ret_state_e  r_state;
    ret_state_e  w_state_nxt;

    logic        w_tag_full;
    logic        w_tag_empty;
    logic        w_tag_head;
    logic        w_deq;
    logic        w_cap;
    logic        w_elig_s;
    logic        w_elig_h;
    logic        w_elig_r;
    logic        w_gnt_valid;
    req_e        w_gnt;
    cmd_t        w_cmd;
    logic        w_gnt_h;
    logic        w_gnt_r;
    logic        w_gnt_s;
    logic        w_push;
    logic [23:0] w_burst_addr;

    // A port with a read outstanding or an ack showing cannot be granted again.
    assign w_elig_s = s_req_i && (r_inflight < MAX_B) && !s_ack_o;
    assign w_elig_h = h_sel_i && !r_busy_h && !h_ack_o && (h_wr_i || !w_tag_full);
    assign w_elig_r = r_sel_i && !r_busy_r && !r_ack_o && (r_wr_i || !w_tag_full);

    assign w_gnt_h      = w_gnt_valid && (w_gnt == REQ_HOST);
    assign w_gnt_r      = w_gnt_valid && (w_gnt == REQ_RASTER);
    assign w_gnt_s      = w_gnt_valid && (w_gnt == REQ_STREAM);
    assign w_push       = (w_gnt_h && !h_wr_i) || (w_gnt_r && !r_wr_i);
    assign w_burst_addr = s_addr_i & BURST_MASK;
    assign reader_deq_o = w_deq;

    // Grant selection: stream first, then host/raster by round-robin pointer
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt       = REQ_HOST;
        if (writer_full_i) begin
            w_gnt_valid = 1'b0;
        end else if (w_elig_s) begin
            w_gnt_valid = 1'b1;
            w_gnt       = REQ_STREAM;
        end else if (w_elig_h && w_elig_r) begin
            w_gnt_valid = 1'b1;
            w_gnt       = r_rr;
        end else if (w_elig_h) begin
            w_gnt_valid = 1'b1;
            w_gnt       = REQ_HOST;
        end else if (w_elig_r) begin
            w_gnt_valid = 1'b1;
            w_gnt       = REQ_RASTER;
        end else begin
            w_gnt_valid = 1'b0;
        end
    end

    // Command word encoding for the granted requester
    always_comb begin
        w_cmd = '0;
        case (w_gnt)
            REQ_STREAM: w_cmd = make_cmd(1'b0, w_burst_addr, BURST_FLAG);
            REQ_HOST:   w_cmd = make_cmd(h_wr_i, h_addr_i, h_wr_i ? h_data_i : 16'h0000);
            REQ_RASTER: w_cmd = make_cmd(r_wr_i, r_addr_i, r_wr_i ? r_data_i : 16'h0000);
            default:    w_cmd = '0;
        endcase
    end

    // Writer interface and stream ack
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            writer_enq_o <= 1'b0;
            writer_d_o   <= '0;
            s_ack_o      <= 1'b0;
        end else begin
            writer_enq_o <= w_gnt_valid;
            s_ack_o      <= w_gnt_s;
            if (w_gnt_valid) begin
                writer_d_o <= w_cmd;
            end
        end
    end

    // Port acks: write ack with enqueue, read ack two cycles after dequeue
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            h_ack_o  <= 1'b0;
            r_ack_o  <= 1'b0;
            h_data_o <= 16'h0000;
            r_data_o <= 16'h0000;
        end else begin
            h_ack_o <= (w_gnt_h && h_wr_i) || (w_cap && !w_tag_head);
            r_ack_o <= (w_gnt_r && r_wr_i) || (w_cap && w_tag_head);
            if (w_cap && !w_tag_head) begin
                h_data_o <= reader_q_i;
            end
            if (w_cap && w_tag_head) begin
                r_data_o <= reader_q_i;
            end
        end
    end

    // Busy flags, round-robin pointer and outstanding burst count
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            r_busy_h   <= 1'b0;
            r_busy_r   <= 1'b0;
            r_rr       <= REQ_HOST;
            r_inflight <= 3'd0;
        end else begin
            if (w_gnt_h && !h_wr_i) begin
                r_busy_h <= 1'b1;
            end else if (w_cap && !w_tag_head) begin
                r_busy_h <= 1'b0;
            end
            if (w_gnt_r && !r_wr_i) begin
                r_busy_r <= 1'b1;
            end else if (w_cap && w_tag_head) begin
                r_busy_r <= 1'b0;
            end
            if (w_gnt_h) begin
                r_rr <= REQ_RASTER;
            end else if (w_gnt_r) begin
                r_rr <= REQ_HOST;
            end
            // A done pulse with nothing in flight is dropped rather than wrapping.
            case ({w_gnt_s, s_burst_done_i && (r_inflight != 3'd0)})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk   (clk_pix),
        .i_reset (reset_i),
        .i_push  (w_push),
        .i_pop   (w_cap),
        .i_data  (w_gnt_r),
        .o_data  (w_tag_head),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    // Return FSM state register
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Return FSM next-state logic
    always_comb begin
        w_state_nxt = R_IDLE;
        case (r_state)
            R_IDLE: begin
                if (!w_tag_empty && !reader_empty_i) begin
                    w_state_nxt = R_DEQ;
                end else begin
                    w_state_nxt = R_IDLE;
                end
            end
            R_DEQ:   w_state_nxt = R_CAP;
            R_CAP:   w_state_nxt = R_IDLE;
            default: w_state_nxt = R_IDLE;
        endcase
    end

    // Return FSM outputs
    always_comb begin
        w_deq = 1'b0;
        w_cap = 1'b0;
        case (r_state)
            R_DEQ:   w_deq = 1'b1;
            R_CAP:   w_cap = 1'b1;
            default: begin
                w_deq = 1'b0;
                w_cap = 1'b0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    logic w_any_elig;
    assign w_any_elig = w_elig_s || w_elig_h || w_elig_r;

    // Grant and stall counters
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            stat_grants_h_o <= 32'd0;
            stat_grants_r_o <= 32'd0;
            stat_grants_s_o <= 32'd0;
            stat_stall_o    <= 32'd0;
        end else begin
            if (w_gnt_h) begin
                stat_grants_h_o <= stat_grants_h_o + 32'd1;
            end
            if (w_gnt_r) begin
                stat_grants_r_o <= stat_grants_r_o + 32'd1;
            end
            if (w_gnt_s) begin
                stat_grants_s_o <= stat_grants_s_o + 32'd1;
            end
            if (w_any_elig && writer_full_i) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed self-checking bench for sdram_cmd_arbiter (default build, MAX_BURSTS=2).
module tb_sdram_cmd_arbiter;

    logic        clk_pix = 1'b0;
    logic        reset_i;
    logic        h_sel_i, h_wr_i, h_ack_o;
    logic [23:0] h_addr_i;
    logic [15:0] h_data_i, h_data_o;
    logic        r_sel_i, r_wr_i, r_ack_o;
    logic [23:0] r_addr_i;
    logic [15:0] r_data_i, r_data_o;
    logic        s_req_i, s_ack_o, s_burst_done_i;
    logic [23:0] s_addr_i;
    logic [40:0] writer_d_o;
    logic        writer_enq_o, writer_full_i;
    logic [15:0] reader_q_i = 16'h0000;
    logic        reader_empty_i;
    logic        reader_deq_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Read-return queue model
    logic [15:0] rq_mem [0:15];
    int          push_cnt = 0;
    int          pop_cnt  = 0;

    always #5 clk_pix = ~clk_pix;

    assign reader_empty_i = (push_cnt == pop_cnt);

    always @(posedge clk_pix) begin
        if (reader_deq_o && (push_cnt != pop_cnt)) begin
            reader_q_i <= rq_mem[pop_cnt % 16];
            pop_cnt    <= pop_cnt + 1;
        end
    end

    sdram_cmd_arbiter #(.MAX_BURSTS(2), .TAG_DEPTH(4)) dut (
        .clk_pix(clk_pix), .reset_i(reset_i),
        .h_sel_i(h_sel_i), .h_wr_i(h_wr_i), .h_addr_i(h_addr_i), .h_data_i(h_data_i),
        .h_ack_o(h_ack_o), .h_data_o(h_data_o),
        .r_sel_i(r_sel_i), .r_wr_i(r_wr_i), .r_addr_i(r_addr_i), .r_data_i(r_data_i),
        .r_ack_o(r_ack_o), .r_data_o(r_data_o),
        .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_ack_o(s_ack_o),
        .s_burst_done_i(s_burst_done_i),
        .writer_d_o(writer_d_o), .writer_enq_o(writer_enq_o), .writer_full_i(writer_full_i),
        .reader_q_i(reader_q_i), .reader_empty_i(reader_empty_i), .reader_deq_o(reader_deq_o)
    );

    task automatic tick();
        @(negedge clk_pix);
    endtask

    task automatic push_ret(input logic [15:0] d);
        rq_mem[push_cnt % 16] = d;
        push_cnt = push_cnt + 1;
    endtask

    task automatic idle_inputs();
        h_sel_i = 1'b0; h_wr_i = 1'b0; h_addr_i = 24'h0; h_data_i = 16'h0;
        r_sel_i = 1'b0; r_wr_i = 1'b0; r_addr_i = 24'h0; r_data_i = 16'h0;
        s_req_i = 1'b0; s_addr_i = 24'h0; s_burst_done_i = 1'b0;
        writer_full_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        push_cnt = pop_cnt;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        n_tests++; if (writer_enq_o !== 1'b0) begin n_fail++; $display("FAIL reset_enq: got %b want 0", writer_enq_o); end
        n_tests++; if (writer_d_o !== 41'h0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", writer_d_o); end
        n_tests++; if ({h_ack_o, r_ack_o, s_ack_o} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {h_ack_o, r_ack_o, s_ack_o}); end
        n_tests++; if (reader_deq_o !== 1'b0) begin n_fail++; $display("FAIL reset_deq: got %b want 0", reader_deq_o); end
        n_tests++; if ({h_data_o, r_data_o} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {h_data_o, r_data_o}); end
        reset_i = 1'b0;
    endtask

    task automatic test_host_write();
        do_reset();
        h_sel_i = 1'b1; h_wr_i = 1'b1; h_addr_i = 24'h000010; h_data_i = 16'hABCD;
        tick();
        n_tests++; if (writer_enq_o !== 1'b1) begin n_fail++; $display("FAIL hw_enq: got %b want 1", writer_enq_o); end
        n_tests++; if (writer_d_o !== {1'b1, 24'h000010, 16'hABCD}) begin n_fail++; $display("FAIL hw_word: got %h want %h", writer_d_o, {1'b1, 24'h000010, 16'hABCD}); end
        n_tests++; if (h_ack_o !== 1'b1) begin n_fail++; $display("FAIL hw_ack: got %b want 1", h_ack_o); end
        h_sel_i = 1'b0;
        tick();
        n_tests++; if ({writer_enq_o, h_ack_o} !== 2'b00) begin n_fail++; $display("FAIL hw_single: got %b want 00", {writer_enq_o, h_ack_o}); end
    endtask

    task automatic test_read_return();
        do_reset();
        push_ret(16'h1111);
        push_ret(16'h2222);
        h_sel_i = 1'b1; h_wr_i = 1'b0; h_addr_i = 24'h000020;
        r_sel_i = 1'b1; r_wr_i = 1'b0; r_addr_i = 24'h000030;
        tick();
        n_tests++; if (writer_enq_o !== 1'b1 || writer_d_o !== {1'b0, 24'h000020, 16'h0000}) begin n_fail++; $display("FAIL rd_first_host: got enq=%b d=%h want 1 %h", writer_enq_o, writer_d_o, {1'b0, 24'h000020, 16'h0000}); end
        tick();
        n_tests++; if (writer_enq_o !== 1'b1 || writer_d_o !== {1'b0, 24'h000030, 16'h0000}) begin n_fail++; $display("FAIL rd_second_raster: got enq=%b d=%h want 1 %h", writer_enq_o, writer_d_o, {1'b0, 24'h000030, 16'h0000}); end
        n_tests++; if (reader_deq_o !== 1'b1) begin n_fail++; $display("FAIL rd_deq1: got %b want 1", reader_deq_o); end
        tick();
        n_tests++; if ({writer_enq_o, reader_deq_o} !== 2'b00) begin n_fail++; $display("FAIL rd_quiet: got %b want 00", {writer_enq_o, reader_deq_o}); end
        tick();
        n_tests++; if (h_ack_o !== 1'b1 || h_data_o !== 16'h1111) begin n_fail++; $display("FAIL rd_host_ret: got ack=%b d=%h want 1 1111", h_ack_o, h_data_o); end
        n_tests++; if (r_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_raster_early: got %b want 0", r_ack_o); end
        h_sel_i = 1'b0;
        tick();
        n_tests++; if (h_ack_o !== 1'b0 || reader_deq_o !== 1'b1) begin n_fail++; $display("FAIL rd_deq2: got ack=%b deq=%b want 0 1", h_ack_o, reader_deq_o); end
        tick();
        tick();
        n_tests++; if (r_ack_o !== 1'b1 || r_data_o !== 16'h2222) begin n_fail++; $display("FAIL rd_raster_ret: got ack=%b d=%h want 1 2222", r_ack_o, r_data_o); end
        r_sel_i = 1'b0;
        tick();
    endtask

    task automatic test_stream_bursts();
        int cnt;
        do_reset();
        s_req_i = 1'b1; s_addr_i = 24'h000100;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (writer_enq_o === 1'b1) begin
                cnt++;
                n_tests++; if (writer_d_o !== {1'b0, 24'h000100, 16'h0001} || s_ack_o !== 1'b1) begin n_fail++; $display("FAIL burst_word: got d=%h ack=%b want %h 1", writer_d_o, s_ack_o, {1'b0, 24'h000100, 16'h0001}); end
            end
        end
        n_tests++; if (cnt != 2) begin n_fail++; $display("FAIL burst_limit: got %0d want 2", cnt); end
        s_burst_done_i = 1'b1;
        tick();
        s_burst_done_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (writer_enq_o === 1'b1) cnt++;
        end
        n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL burst_after_done: got %0d want 1", cnt); end
        s_req_i = 1'b0;
    endtask

    task automatic test_priority();
        logic [1:0] exp_seq [22];
        logic [1:0] got     [22];
        int         n;
        int         n_r;
        do_reset();
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd0; exp_seq[2] = 2'd2; exp_seq[3] = 2'd1;
        for (int k = 4; k < 22; k++) exp_seq[k] = (k % 2 == 0) ? 2'd0 : 2'd1;
        for (int k = 0; k < 22; k++) got[k] = 2'd3;
        s_req_i = 1'b1; s_addr_i = 24'h000100;
        h_sel_i = 1'b1; h_wr_i = 1'b1; h_addr_i = 24'h000A00; h_data_i = 16'h0001;
        r_sel_i = 1'b1; r_wr_i = 1'b1; r_addr_i = 24'h000B00; r_data_i = 16'h0002;
        n = 0;
        for (int c = 0; c < 60 && n < 22; c++) begin
            tick();
            if (writer_enq_o === 1'b1) begin
                case (writer_d_o[39:16])
                    24'h000A00: got[n] = 2'd0;
                    24'h000B00: got[n] = 2'd1;
                    24'h000100: got[n] = 2'd2;
                    default:    got[n] = 2'd3;
                endcase
                n++;
            end
        end
        n_r = 0;
        for (int k = 0; k < 22; k++) begin
            if (got[k] == 2'd1) n_r++;
            n_tests++; if (got[k] !== exp_seq[k]) begin n_fail++; $display("FAIL prio_order[%0d]: got %0d want %0d (0=host 1=raster 2=stream)", k, got[k], exp_seq[k]); end
        end
        n_tests++; if (n_r != 10) begin n_fail++; $display("FAIL prio_raster_share: got %0d want 10", n_r); end
        idle_inputs();
        tick();
    endtask

    task automatic test_writer_full();
        do_reset();
        writer_full_i = 1'b1;
        h_sel_i = 1'b1; h_wr_i = 1'b1; h_addr_i = 24'h000040; h_data_i = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if ({writer_enq_o, h_ack_o} !== 2'b00) begin n_fail++; $display("FAIL full_hold[%0d]: got %b want 00", i, {writer_enq_o, h_ack_o}); end
        end
        writer_full_i = 1'b0;
        tick();
        n_tests++; if (writer_enq_o !== 1'b1 || h_ack_o !== 1'b1 || writer_d_o !== {1'b1, 24'h000040, 16'h5555}) begin n_fail++; $display("FAIL full_release: got enq=%b ack=%b d=%h want 1 1 %h", writer_enq_o, h_ack_o, writer_d_o, {1'b1, 24'h000040, 16'h5555}); end
        h_sel_i = 1'b0;
        tick();
        n_tests++; if (writer_enq_o !== 1'b0) begin n_fail++; $display("FAIL full_single: got %b want 0", writer_enq_o); end
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        int deq_seen;
        int ack_seen;
        do_reset();
        s_req_i = 1'b1; s_addr_i = 24'h000200;
        for (int i = 0; i < 6; i++) tick();
        s_req_i = 1'b0;
        push_ret(16'h3333);
        h_sel_i = 1'b1; h_wr_i = 1'b0; h_addr_i = 24'h000050;
        tick();
        tick();
        n_tests++; if (reader_deq_o !== 1'b1) begin n_fail++; $display("FAIL mid_in_deq: got %b want 1", reader_deq_o); end
        reset_i = 1'b1;
        h_sel_i = 1'b0;
        tick();
        n_tests++; if ({h_ack_o, r_ack_o, reader_deq_o, writer_enq_o} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_outs: got %b want 0000", {h_ack_o, r_ack_o, reader_deq_o, writer_enq_o}); end
        reset_i = 1'b0;
        push_ret(16'h4444);
        s_req_i = 1'b1;
        cnt = 0; deq_seen = 0; ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (writer_enq_o === 1'b1) cnt++;
            if (reader_deq_o !== 1'b0) deq_seen++;
            if (h_ack_o !== 1'b0 || r_ack_o !== 1'b0) ack_seen++;
        end
        n_tests++; if (deq_seen != 0) begin n_fail++; $display("FAIL mid_tags_flushed: got %0d deq cycles want 0", deq_seen); end
        n_tests++; if (ack_seen != 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d ack cycles want 0", ack_seen); end
        n_tests++; if (cnt != 2) begin n_fail++; $display("FAIL mid_inflight_cleared: got %0d bursts want 2", cnt); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_i = 1'b0;
        test_reset();
        test_host_write();
        test_read_return();
        test_stream_bursts();
        test_priority();
        test_writer_full();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
